pc_word_arbiter: RTL



---
 rtl/pc_word_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pc_word_arbiter.sv
// rtl/pc_word_arbiter.sv - round-robin, message-locked merge of PC word streams
//
// Merges Nin serialized PC-word sources onto one upstream word channel.
// Arbitration is round-robin at message granularity: once a source's first
// chunk (in_last=0) is taken, only that source is served until its final
// chunk is taken. A single registered output stage sustains 1 word/cycle.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   in_v         per-source valid
//   in_last      per-source "current chunk ends its message"
//   in_code      per-source code, source i at [i*Ncode +: Ncode]
//   in_payload   per-source payload, source i at [i*Ndata +: Ndata]
//   in_a         per-source ack (combinational, at most one bit set)
//   out_v        output valid (registered)
//   out_code     output code (registered)
//   out_payload  output payload (registered)
//   out_src      index of the source that produced the current output word
//   out_a        output ack
//   locked       high while a multi-chunk message is in progress
module pc_word_arbiter #(
  parameter int Nin   = 4,
  parameter int Ncode = 8,
  parameter int Ndata = 24,
  localparam int Nsrc = $clog2(Nin)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [Nin-1:0]         in_v,
  input  logic [Nin-1:0]         in_last,
  input  logic [Nin*Ncode-1:0]   in_code,
  input  logic [Nin*Ndata-1:0]   in_payload,
  output logic [Nin-1:0]         in_a,
  output logic                   out_v,
  output logic [Ncode-1:0]       out_code,
  output logic [Ndata-1:0]       out_payload,
  output logic [Nsrc-1:0]        out_src,
  input  logic                   out_a,
  output logic                   locked
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [Nsrc-1:0]   owner_q, owner_d;
  logic [Nsrc-1:0]   rr_ptr_q, rr_ptr_d;
  logic [Nsrc-1:0]   sel_idx;
  logic              sel_found;
  logic              sel_last;
  logic              can_load;
  logic              accept;
  logic [Ncode-1:0]  code_arr    [Nin];
  logic [Ndata-1:0]  payload_arr [Nin];

  // Increment modulo Nin (Nin need not be a power of two).
  function automatic logic [Nsrc-1:0] wrap_inc(input logic [Nsrc-1:0] x);
    if (int'(x) == Nin - 1) return '0;
    return x + 1'b1;
  endfunction

  // Candidate k positions after base in the round-robin scan, modulo Nin.
  function automatic logic [Nsrc-1:0] rr_index(input logic [Nsrc-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= Nin) s = s - Nin;
    return s[Nsrc-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < Nin; i++) begin
      code_arr[i]    = in_code[i*Ncode +: Ncode];
      payload_arr[i] = in_payload[i*Ndata +: Ndata];
    end
  end

  // Selection: the owner alone while locked, otherwise the first valid source
  // starting at rr_ptr. The scan runs backwards so the nearest candidate wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    if (state_q == LOCKED) begin
      sel_found = in_v[owner_q];
      sel_idx   = owner_q;
    end else begin
      for (int k = Nin - 1; k >= 0; k--) begin
        if (in_v[rr_index(rr_ptr_q, k)]) begin
          sel_found = 1'b1;
          sel_idx   = rr_index(rr_ptr_q, k);
        end
      end
    end
  end

  assign can_load = !out_v || out_a;
  // reset_n gates the ack so no source sees a transfer while held in reset.
  assign accept   = reset_n && can_load && sel_found;
  assign sel_last = in_last[sel_idx];

  // State register, including the output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_v       <= 1'b0;
      out_code    <= '0;
      out_payload <= '0;
      out_src     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        out_v       <= 1'b1;
        out_code    <= code_arr[sel_idx];
        out_payload <= payload_arr[sel_idx];
        out_src     <= sel_idx;
      end else if (out_a) begin
        out_v <= 1'b0;
      end
    end
  end

  // Next state: rr_ptr moves only when a message completes, never per chunk.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (sel_last) begin
            rr_ptr_d = wrap_inc(sel_idx);
          end else begin
            state_d = LOCKED;
            owner_d = sel_idx;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from state and selection.
  always_comb begin
    in_a = '0;
    if (accept) in_a[sel_idx] = 1'b1;
  end

  assign locked = (state_q == LOCKED);

endmodule
